pipe_reg_bank: RTL and testbench
================================

PIPE_REG_BANK -- requirements
Module: pipe_reg_bank

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one lane's data.
REQ-002 Parameter LANES, default 2, number of parallel issue lanes per stage.
REQ-003 Port clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 Port arst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  upstream offers a stage bundle.
REQ-006 Port in_ready  output  1  block accepts the bundle this cycle.
REQ-007 Port in_data  input  LANES*WIDTH  lane data, lane k at bits [k*WIDTH +: WIDTH].
REQ-008 Port in_lane_vld  input  LANES  per-lane valid bits of the offered bundle.
REQ-009 Port out_valid  output  1  bundle available downstream.
REQ-010 Port out_ready  input  1  downstream consumes the bundle this cycle.
REQ-011 Port out_data  output  LANES*WIDTH  head bundle data, same lane packing.
REQ-012 Port out_lane_vld  output  LANES  head bundle per-lane valid bits.
REQ-013 Port flush  input  1  synchronous pipeline kill.
REQ-014 Port inject  input  1  synchronous forced load of inject_data (successor of async load).
REQ-015 Port inject_data  input  LANES*WIDTH  data loaded on inject.
REQ-016 Port inject_lane_vld  input  LANES  lane valids loaded on inject.
REQ-017 Port occupancy  output  2  number of stored bundles: 0, 1 or 2.

Function
REQ-018 Storage: main register (head) and skid register, each LANES*WIDTH data plus LANES lane-valid bits.
REQ-019 State machine: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full).
REQ-020 accept = in_valid & in_ready; drain = out_valid & out_ready.
REQ-021 in_ready = (state != TWO) & ~inject & ~flush, combinational from registered state.
REQ-022 out_valid = (state != EMPTY); out_data = main data; out_lane_vld = main lane valids when out_valid, else all zero.
REQ-023 EMPTY: accept -> ONE, main <= input; otherwise stay EMPTY.
REQ-024 ONE: accept & drain -> ONE, main <= input; accept & ~drain -> TWO, skid <= input; ~accept & drain -> EMPTY; neither -> hold.
REQ-025 TWO: drain -> ONE, main <= skid; ~drain -> hold; no accept possible.
REQ-026 Latency: accepted bundle is visible on out_data one cycle after acceptance when the block was EMPTY or draining from ONE.
REQ-027 Ordering: bundles leave in acceptance order; no bundle is duplicated or dropped except by flush or inject.
REQ-028 Priority per edge: arst > flush > inject > normal handshake.
REQ-029 flush: state -> EMPTY next cycle, all stored lane valids cleared, data registers hold value; input offered that cycle is discarded; drain that cycle still counts as completed downstream.
REQ-030 inject (no flush): state -> ONE, main <= inject_data/inject_lane_vld, skid discarded; a drain that same cycle completes with old main contents; undrained old contents are overwritten.
REQ-031 Lane valids are carried through unmodified; a bundle with all lane valids zero is still a bundle for the handshake.
REQ-032 occupancy equals 0/1/2 for EMPTY/ONE/TWO, registered.

Reset
REQ-033 arst high at a clock edge: state -> EMPTY, main and skid data and lane valids -> 0, regardless of other inputs.
REQ-034 During and one cycle after reset: out_valid = 0, out_lane_vld = 0, occupancy = 0; in_ready = 1 once arst is low.
REQ-035 Reset asserted mid-transfer discards all stored bundles; no partial update survives.

Verification
REQ-036 Reset, then in_valid=1, in_data lane0=0x11, lane1=0x22, lane_vld=2'b11, out_ready=1 -> next cycle out_valid=1, out_data={0x22,0x11}, occupancy=1.
REQ-037 out_ready=0, accept bundles A then B -> occupancy=2, in_ready=0; raise out_ready -> A then B emerge on consecutive cycles, occupancy 2->1->0.
REQ-038 State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, out_lane_vld=0, occupancy=0, offered input not stored.
REQ-039 State ONE holding A, inject with inject_data lane0=0xDEAD, out_ready=0 -> next cycle out_data lane0=0xDEAD, occupancy=1, A never seen; in_ready=0 during inject cycle.
REQ-040 Flush and inject in same cycle -> flush wins: occupancy=0, inject_data not stored.
REQ-041 Random valid/ready streaming 1000 bundles with scoreboard -> output sequence equals input sequence, no loss or duplication.

Source files
------------

// File: rtl/pipe_reg_bank.sv
// Two-entry pipeline register bank (main + skid) carrying LANES data lanes with
// per-lane valids, valid/ready handshake, synchronous flush and forced inject.
module pipe_reg_bank #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 2
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic [LANES-1:0]         in_lane_vld,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [LANES-1:0]         out_lane_vld,
  input  logic                     flush,
  input  logic                     inject,
  input  logic [LANES*WIDTH-1:0]   inject_data,
  input  logic [LANES-1:0]         inject_lane_vld,
  output logic [1:0]               occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [LANES*WIDTH-1:0]   main_data_q, main_data_d;
  logic [LANES-1:0]         main_vld_q, main_vld_d;
  logic [LANES*WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [LANES-1:0]         skid_vld_q, skid_vld_d;

  logic accept;
  logic drain;

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_vld_q  <= '0;
      skid_data_q <= '0;
      skid_vld_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
    end
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_vld_d  = main_vld_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    if (flush) begin
      // Data registers keep their contents; only the lane valids are killed.
      state_d    = ST_EMPTY;
      main_vld_d = '0;
      skid_vld_d = '0;
    end else if (inject) begin
      state_d     = ST_ONE;
      main_data_d = inject_data;
      main_vld_d  = inject_lane_vld;
      skid_vld_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_vld_d  = in_lane_vld;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data_d = in_data;
            main_vld_d  = in_lane_vld;
          end else if (accept) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_vld_d  = in_lane_vld;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_vld_d  = skid_vld_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready     = (state_q != ST_TWO) & ~inject & ~flush;
    out_valid    = (state_q != ST_EMPTY);
    out_data     = main_data_q;
    out_lane_vld = out_valid ? main_vld_q : '0;
    case (state_q)
      ST_ONE:  occupancy = 2'd1;
      ST_TWO:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_reg_bank.sv
// Directed and scoreboarded streaming checks for pipe_reg_bank (WIDTH=32, LANES=2).
module tb_pipe_reg_bank;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LANES = 2;

  logic                   clk = 1'b0;
  logic                   arst;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       in_lane_vld;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_lane_vld;
  logic                   flush;
  logic                   inject;
  logic [LANES*WIDTH-1:0] inject_data;
  logic [LANES-1:0]       inject_lane_vld;
  logic [1:0]             occupancy;

  int pass_cnt  = 0;
  int check_cnt = 0;

  pipe_reg_bank #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .arst(arst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_lane_vld(in_lane_vld),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lane_vld(out_lane_vld),
    .flush(flush), .inject(inject), .inject_data(inject_data), .inject_lane_vld(inject_lane_vld),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] DA = {32'h0000_00A1, 32'h0000_00A0};
  localparam logic [63:0] DB = {32'h0000_00B1, 32'h0000_00B0};
  localparam logic [63:0] DC = {32'h0000_00C1, 32'h0000_00C0};
  localparam logic [63:0] DI = {32'h0000_BEEF, 32'h0000_DEAD};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; flush = 0; inject = 0;
  endtask

  task automatic offer(input logic [63:0] d, input logic [1:0] v);
    in_valid = 1; in_data = d; in_lane_vld = v;
  endtask

  task automatic test_reset();
    arst = 1; idle(); in_data = '0; in_lane_vld = '0; inject_data = '0; inject_lane_vld = '0;
    tick(); tick();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    check_cnt++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else pass_cnt++;
    arst = 0; #1;
    check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    tick();
    check_cnt++; if (out_valid !== 1'b0 || out_lane_vld !== 2'b00 || occupancy !== 2'd0)
      $display("FAIL post_reset got v=%b lv=%b occ=%0d want 0/00/0", out_valid, out_lane_vld, occupancy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    out_ready = 1; offer({32'h22, 32'h11}, 2'b11);
    tick();
    in_valid = 0; #1;
    check_cnt++; if (out_valid !== 1'b1 || out_data !== {32'h22, 32'h11} || occupancy !== 2'd1 || out_lane_vld !== 2'b11)
      $display("FAIL basic got v=%b d=%h occ=%0d lv=%b want 1/%h/1/11", out_valid, out_data, occupancy, out_lane_vld, {32'h22, 32'h11});
    else pass_cnt++;
    tick();
    check_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL basic_drain got occ=%0d v=%b want 0/0", occupancy, out_valid); else pass_cnt++;
    idle();
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    offer(DA, 2'b01); tick();
    offer(DB, 2'b10); tick();
    in_valid = 0; #1;
    check_cnt++; if (occupancy !== 2'd2 || in_ready !== 1'b0) $display("FAIL b2b_full got occ=%0d rdy=%b want 2/0", occupancy, in_ready); else pass_cnt++;
    out_ready = 1; #1;
    check_cnt++; if (out_data !== DA || out_lane_vld !== 2'b01) $display("FAIL b2b_first got %h/%b want %h/01", out_data, out_lane_vld, DA); else pass_cnt++;
    tick();
    check_cnt++; if (occupancy !== 2'd1 || out_data !== DB || out_lane_vld !== 2'b10)
      $display("FAIL b2b_second got occ=%0d d=%h lv=%b want 1/%h/10", occupancy, out_data, out_lane_vld, DB);
    else pass_cnt++;
    tick();
    check_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL b2b_empty got occ=%0d v=%b want 0/0", occupancy, out_valid); else pass_cnt++;
    idle();
  endtask

  task automatic test_flush();
    offer(DA, 2'b11); tick();
    offer(DB, 2'b11); tick();
    offer(DC, 2'b11); flush = 1; #1;
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else pass_cnt++;
    tick();
    flush = 0; in_valid = 0; #1;
    check_cnt++; if (out_valid !== 1'b0 || out_lane_vld !== 2'b00 || occupancy !== 2'd0)
      $display("FAIL flush got v=%b lv=%b occ=%0d want 0/00/0", out_valid, out_lane_vld, occupancy);
    else pass_cnt++;
    tick(); tick();
    check_cnt++; if (occupancy !== 2'd0) $display("FAIL flush_no_store got occ=%0d want 0", occupancy); else pass_cnt++;
    idle();
  endtask

  task automatic test_inject();
    offer(DA, 2'b11); tick();
    offer(DB, 2'b11); inject = 1; inject_data = DI; inject_lane_vld = 2'b01; #1;
    check_cnt++; if (in_ready !== 1'b0) $display("FAIL inject_in_ready got %b want 0", in_ready); else pass_cnt++;
    tick();
    inject = 0; in_valid = 0; #1;
    check_cnt++; if (out_data[31:0] !== 32'hDEAD || out_data !== DI || occupancy !== 2'd1 || out_lane_vld !== 2'b01)
      $display("FAIL inject got d=%h occ=%0d lv=%b want %h/1/01", out_data, occupancy, out_lane_vld, DI);
    else pass_cnt++;
    out_ready = 1; tick();
    check_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL inject_drain got occ=%0d v=%b want 0/0", occupancy, out_valid); else pass_cnt++;
    // inject from TWO discards the skid entry
    out_ready = 0;
    offer(DA, 2'b11); tick();
    offer(DB, 2'b11); tick();
    in_valid = 0; inject = 1; tick();
    inject = 0; #1;
    check_cnt++; if (occupancy !== 2'd1 || out_data !== DI) $display("FAIL inject_two got occ=%0d d=%h want 1/%h", occupancy, out_data, DI); else pass_cnt++;
    out_ready = 1; tick();
    check_cnt++; if (occupancy !== 2'd0) $display("FAIL inject_skid_dropped got occ=%0d want 0", occupancy); else pass_cnt++;
    idle();
  endtask

  task automatic test_flush_inject();
    offer(DA, 2'b11); tick();
    in_valid = 0; flush = 1; inject = 1; inject_data = DI; inject_lane_vld = 2'b11;
    tick();
    flush = 0; inject = 0; #1;
    check_cnt++; if (occupancy !== 2'd0 || out_lane_vld !== 2'b00) $display("FAIL flush_inject got occ=%0d lv=%b want 0/00", occupancy, out_lane_vld); else pass_cnt++;
    check_cnt++; if (out_data !== DA) $display("FAIL flush_inject_data got %h want %h", out_data, DA); else pass_cnt++;
    idle();
  endtask

  task automatic test_zero_lanes();
    offer(DC, 2'b00); tick();
    in_valid = 0; #1;
    check_cnt++; if (out_valid !== 1'b1 || occupancy !== 2'd1 || out_lane_vld !== 2'b00 || out_data !== DC)
      $display("FAIL zero_lanes got v=%b occ=%0d lv=%b d=%h want 1/1/00/%h", out_valid, occupancy, out_lane_vld, out_data, DC);
    else pass_cnt++;
    out_ready = 1; tick(); idle();
  endtask

  task automatic test_reset_mid();
    offer(DA, 2'b11); tick();
    offer(DB, 2'b11); tick();
    arst = 1; out_ready = 1; tick();
    arst = 0; in_valid = 0; out_ready = 0; #1;
    check_cnt++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 64'd0)
      $display("FAIL reset_mid got occ=%0d v=%b d=%h want 0/0/0", occupancy, out_valid, out_data);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_stream();
    logic [65:0] q[$];
    logic [65:0] exp;
    int sent = 0;
    int cycles = 0;
    int errs = 0;
    while (!(sent >= 1000 && q.size() == 0) && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
      in_valid    = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data     = {$urandom(), $urandom()};
      in_lane_vld = 2'($urandom_range(0, 3));
      out_ready   = ($urandom_range(0, 2) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back({in_lane_vld, in_data});
        sent++;
      end
      if (out_valid && out_ready) begin
        check_cnt++;
        if (q.size() == 0) begin
          $display("FAIL stream_extra got %h with empty scoreboard", out_data);
          errs++;
        end else begin
          exp = q.pop_front();
          if ({out_lane_vld, out_data} !== exp) begin
            if (errs < 10) $display("FAIL stream_data got %h want %h", {out_lane_vld, out_data}, exp);
            errs++;
          end else pass_cnt++;
        end
      end
    end
    check_cnt++;
    if (sent < 1000 || q.size() != 0) $display("FAIL stream_timeout got sent=%0d pending=%0d want 1000/0", sent, q.size());
    else pass_cnt++;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_inject();
    test_flush_inject();
    test_zero_lanes();
    test_reset_mid();
    test_stream();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
